// File: rtl/par_ser_pkg.sv
// Shared definitions for the DWT parallel-to-serial output stage.
package par_ser_pkg;

  localparam int unsigned NLANE    = 6;
  localparam int unsigned SAMPLE_W = 18;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/par_ser_word_reg.sv
// One multi-lane word register with load enable; cleared by reset.
module par_ser_word_reg #(
  parameter int unsigned W = 18,
  parameter int unsigned N = 6
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           load,
  input  logic [N*W-1:0] d,
  output logic [N*W-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/par_ser.sv
// Six-lane parallel-to-serial converter with a one-word hold buffer and sticky overflow.
module par_ser
  import par_ser_pkg::*;
#(
  parameter int unsigned W = SAMPLE_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                valid_in,
  input  logic signed [W-1:0] data_in_0,
  input  logic signed [W-1:0] data_in_1,
  input  logic signed [W-1:0] data_in_2,
  input  logic signed [W-1:0] data_in_3,
  input  logic signed [W-1:0] data_in_4,
  input  logic signed [W-1:0] data_in_5,
  input  logic                clr_ovf,
  output logic signed [W-1:0] data_out,
  output logic                valid_out,
  output logic                frame_start,
  output logic                ready,
  output logic                overflow
);

  localparam int unsigned WORD_W = NLANE * W;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hold_full_q, hold_full_d;
  logic [W-1:0]      dout_d;
  logic              vout_d, fs_d, ovf_d, ovf_set;
  logic              act_ld, act_from_hold, hold_ld;
  logic [WORD_W-1:0] din_word, act_d, act_q, hold_q;

  function automatic logic [W-1:0] lane_of(input logic [WORD_W-1:0] w,
                                           input logic [IDX_W-1:0]  sel);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (sel == IDX_W'(i)) r = w[i*W +: W];
    end
    return r;
  endfunction

  assign din_word = {data_in_5, data_in_4, data_in_3, data_in_2, data_in_1, data_in_0};
  assign act_d    = act_from_hold ? hold_q : din_word;
  assign ready    = ~hold_full_q;

  par_ser_word_reg #(.W(W), .N(NLANE)) u_active (
    .clk  (clk),
    .rstn (rstn),
    .load (act_ld),
    .d    (act_d),
    .q    (act_q)
  );

  par_ser_word_reg #(.W(W), .N(NLANE)) u_hold (
    .clk  (clk),
    .rstn (rstn),
    .load (hold_ld),
    .d    (din_word),
    .q    (hold_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hold_full_q <= 1'b0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_full_q <= hold_full_d;
      data_out    <= dout_d;
      valid_out   <= vout_d;
      frame_start <= fs_d;
      overflow    <= ovf_d;
    end
  end

  // idx_q == 0 in RUN means lane 5 is on data_out: the word boundary
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    hold_full_d   = hold_full_q;
    dout_d        = data_out;
    vout_d        = 1'b0;
    fs_d          = 1'b0;
    ovf_set       = 1'b0;
    act_ld        = 1'b0;
    act_from_hold = 1'b0;
    hold_ld       = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          act_ld  = 1'b1;
          dout_d  = data_in_0;
          idx_d   = IDX_W'(1);
          vout_d  = 1'b1;
          fs_d    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        vout_d = 1'b1;
        if (idx_q == '0) begin
          if (hold_full_q) begin
            act_ld        = 1'b1;
            act_from_hold = 1'b1;
            dout_d        = lane_of(hold_q, IDX_W'(0));
            idx_d         = IDX_W'(1);
            fs_d          = 1'b1;
            hold_ld       = valid_in;
            hold_full_d   = valid_in;
          end else if (valid_in) begin
            act_ld = 1'b1;
            dout_d = data_in_0;
            idx_d  = IDX_W'(1);
            fs_d   = 1'b1;
          end else begin
            vout_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          dout_d = lane_of(act_q, idx_q);
          idx_d  = (idx_q == IDX_W'(NLANE - 1)) ? '0 : idx_q + IDX_W'(1);
          if (valid_in) begin
            if (!hold_full_q) begin
              hold_ld     = 1'b1;
              hold_full_d = 1'b1;
            end else begin
              ovf_set = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ovf_d = ovf_set | (overflow & ~clr_ovf);
  end

endmodule

// File: tb/tb_par_ser.sv
// Bench for par_ser: directed scenarios plus random strobes against a sample-queue model.
module tb_par_ser;
  import par_ser_pkg::*;

  localparam int unsigned W = 18;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                valid_in = 1'b0;
  logic                clr_ovf = 1'b0;
  logic signed [W-1:0] din [NLANE];
  logic signed [W-1:0] data_out;
  logic                valid_out, frame_start, ready, overflow;

  int n_checks = 0;
  int n_err    = 0;

  // Model: queue of samples still to appear on data_out, tagged with their lane
  logic signed [W-1:0] mq[$];
  int                  lq[$];
  logic signed [W-1:0] m_dout  = '0;
  bit                  m_valid = 1'b0;
  bit                  m_fs    = 1'b0;
  bit                  m_ovf   = 1'b0;
  bit                  m_ready = 1'b1;
  bit                  m_drop;

  always #5 clk = ~clk;

  par_ser #(.W(W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .valid_in    (valid_in),
    .data_in_0   (din[0]),
    .data_in_1   (din[1]),
    .data_in_2   (din[2]),
    .data_in_3   (din[3]),
    .data_in_4   (din[4]),
    .data_in_5   (din[5]),
    .clr_ovf     (clr_ovf),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .frame_start (frame_start),
    .ready       (ready),
    .overflow    (overflow)
  );

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A word is taken while at most one word's worth of samples is still pending
  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        mq.delete();
        lq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_fs    = 1'b0;
        m_ovf   = 1'b0;
        m_ready = 1'b1;
      end else begin
        m_drop = 1'b0;
        if (valid_in) begin
          if (mq.size() <= NLANE) begin
            for (int p = 0; p < NLANE; p++) begin
              mq.push_back(din[p]);
              lq.push_back(p);
            end
          end else begin
            m_drop = 1'b1;
          end
        end
        if (m_drop) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (mq.size() > 0) begin
          m_dout  = mq.pop_front();
          m_fs    = (lq.pop_front() == 0);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
          m_fs    = 1'b0;
        end
        m_ready = (mq.size() < NLANE);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("valid_out", valid_out, m_valid);
        chk("frame_start", frame_start, m_fs);
        chk("overflow", overflow, m_ovf);
        chk("ready", ready, m_ready);
        if (m_valid) chk("data_out", data_out, m_dout);
      end
    end
  end

  task automatic cyc(input bit v, input bit c);
    valid_in = v;
    clr_ovf  = c;
    @(negedge clk);
  endtask

  task automatic setw(input int base);
    for (int p = 0; p < NLANE; p++) din[p] = W'(base + p);
  endtask

  initial begin
    setw(0);
    repeat (2) @(negedge clk);
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_frame", frame_start, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", ready, 1);
    rstn = 1'b1;

    // Single word 10..15
    setw(10);
    cyc(1, 0);
    chk("w1_data0", data_out, 10);
    chk("w1_fs0", frame_start, 1);
    chk("w1_valid0", valid_out, 1);
    for (int i = 1; i < 6; i++) begin
      cyc(0, 0);
      chk("w1_data", data_out, 10 + i);
      chk("w1_fs", frame_start, 0);
    end
    cyc(0, 0);
    chk("w1_idle_valid", valid_out, 0);
    chk("w1_idle_data", data_out, 15);
    repeat (2) cyc(0, 0);

    // Gapless ramp, one word with negative lanes
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < NLANE; p++)
        din[p] = (k == 3) ? W'(-131072 + p) : W'(6 * k + p);
      cyc(1, 0);
      if (k == 3) chk("ramp_neg", data_out, -131072);
      repeat (5) cyc(0, 0);
      chk("ramp_valid", valid_out, 1);
    end
    chk("ramp_last", data_out, 47);
    chk("ramp_ovf", overflow, 0);
    repeat (2) cyc(0, 0);

    // Strobes at E0, E2, E3
    setw(100); cyc(1, 0);
    cyc(0, 0);
    setw(200); cyc(1, 0);
    chk("e2_ready", ready, 0);
    setw(300); cyc(1, 0);
    chk("e3_ovf", overflow, 1);
    chk("e3_ready", ready, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk("e5_ready", ready, 0);
    chk("e5_data", data_out, 105);
    cyc(0, 0);
    chk("e6_ready", ready, 1);
    chk("e6_data", data_out, 200);
    chk("e6_fs", frame_start, 1);
    repeat (6) cyc(0, 0);
    chk("e12_valid", valid_out, 0);
    chk("e12_data", data_out, 205);

    // Drop coinciding with clr_ovf keeps overflow; lone clr_ovf clears it
    setw(400); cyc(1, 0);
    setw(500); cyc(1, 0);
    setw(600); cyc(1, 1);
    chk("clr_race_ovf", overflow, 1);
    cyc(0, 1);
    chk("clr_ovf", overflow, 0);
    repeat (10) cyc(0, 0);

    // Reset at lane 3 with hold full
    setw(700); cyc(1, 0);
    setw(800); cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk("pre_rst_data", data_out, 703);
    chk("pre_rst_ready", ready, 0);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_fs", frame_start, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_ready", ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) cyc(0, 0);
    chk("post_rst_valid", valid_out, 0);
    chk("post_rst_data", data_out, 0);

    // Strobes every 9 cycles
    for (int k = 0; k < 5; k++) begin
      setw(1000 + 10 * k);
      cyc(1, 0);
      chk("p9_fs", frame_start, 1);
      chk("p9_data", data_out, 1000 + 10 * k);
      repeat (8) cyc(0, 0);
      chk("p9_gap", valid_out, 0);
    end

    // Random strobes, data and clears
    repeat (3000) begin
      for (int p = 0; p < NLANE; p++) din[p] = W'($urandom);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end
    repeat (15) cyc(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
